time_set_ctrl: RTL

Time-setting controller for the real-time clock. Sits between the timekeeper and the 4-digit display driver. In normal mode it forwards the running HH:MM digits to the display. On a mode button it runs an edit sequence (hours, then minutes), blinks the field being edited and drives the new BCD time back to the timekeeper with a one-cycle load strobe.

---
 rtl/rtc_pkg.sv | 27 ++
 rtl/bcd_updown_pair.sv | 85 ++++++++
 rtl/time_set_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the real-time-clock time-setting path.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_COMMIT  = 2'b11
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned HR_MAX  = 32'd23;
    localparam int unsigned MIN_MAX = 32'd59;

    localparam logic [3:0] BLANK_HR  = 4'b1100;
    localparam logic [3:0] BLANK_MIN = 4'b0011;

    // True when both nibbles are decimal digits and the pair does not exceed max_val.
    function automatic logic bcd_pair_valid(input bcd_t left, input bcd_t right,
                                            input int unsigned max_val);
        int unsigned value;
        value = 32'(left) * 32'd10 + 32'(right);
        return (left <= 4'd9) && (right <= 4'd9) && (value <= max_val);
    endfunction

endpackage

// File: rtl/bcd_updown_pair.sv
// Two-digit BCD register counting 00..MAX with wrap-around in both
// directions. A load of an out-of-range or non-BCD value is sanitised to 00.
// The next-state value is exported so the owner can register it into its
// outputs in the same cycle the register itself updates.
module bcd_updown_pair
    import rtc_pkg::*;
#(
    parameter int unsigned MAX = 32'd59
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_left_i,
    input  logic [3:0] load_right_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] left_o,
    output logic [3:0] right_o,
    output logic [3:0] nxt_left_o,
    output logic [3:0] nxt_right_o
);

    localparam bcd_t MAX_L = 4'(MAX / 32'd10);
    localparam bcd_t MAX_R = 4'(MAX % 32'd10);

    bcd_t left_r;
    bcd_t right_r;
    bcd_t left_nxt_s;
    bcd_t right_nxt_s;

    // Next value: load has priority, then increment, then decrement, else hold.
    always_comb begin
        left_nxt_s  = left_r;
        right_nxt_s = right_r;
        if (load_i) begin
            if (bcd_pair_valid(load_left_i, load_right_i, MAX)) begin
                left_nxt_s  = load_left_i;
                right_nxt_s = load_right_i;
            end else begin
                left_nxt_s  = 4'd0;
                right_nxt_s = 4'd0;
            end
        end else if (inc_i) begin
            if ((left_r == MAX_L) && (right_r == MAX_R)) begin
                left_nxt_s  = 4'd0;
                right_nxt_s = 4'd0;
            end else if (right_r == 4'd9) begin
                left_nxt_s  = left_r + 4'd1;
                right_nxt_s = 4'd0;
            end else begin
                right_nxt_s = right_r + 4'd1;
            end
        end else if (dec_i) begin
            if ((left_r == 4'd0) && (right_r == 4'd0)) begin
                left_nxt_s  = MAX_L;
                right_nxt_s = MAX_R;
            end else if (right_r == 4'd0) begin
                left_nxt_s  = left_r - 4'd1;
                right_nxt_s = 4'd9;
            end else begin
                right_nxt_s = right_r - 4'd1;
            end
        end else begin
            left_nxt_s  = left_r;
            right_nxt_s = right_r;
        end
    end

    // Digit register with synchronous active-low reset to 00.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            left_r  <= 4'd0;
            right_r <= 4'd0;
        end else begin
            left_r  <= left_nxt_s;
            right_r <= right_nxt_s;
        end
    end

    assign left_o      = left_r;
    assign right_o     = right_r;
    assign nxt_left_o  = left_nxt_s;
    assign nxt_right_o = right_nxt_s;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: forwards running HH:MM to the display, runs the
// hours/minutes edit sequence with field blinking and an idle timeout, and
// hands the edited time back to the timekeeper with a one-cycle load strobe.
module time_set_ctrl
    import rtc_pkg::*;
#(
    parameter logic [31:0] BLINK_HALF = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT    = 32'd3_000_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic [3:0] run_hr_left_i,
    input  logic [3:0] run_hr_right_i,
    input  logic [3:0] run_min_left_i,
    input  logic [3:0] run_min_right_i,
    output logic [3:0] hr_left_o,
    output logic [3:0] hr_right_o,
    output logic [3:0] min_left_o,
    output logic [3:0] min_right_o,
    output logic [3:0] blank_o,
    output logic       load_o,
    output logic [1:0] mode_o
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] blink_cnt_r;
    logic [31:0] blink_cnt_nxt_s;
    logic        phase_on_r;
    logic        phase_on_nxt_s;
    logic [31:0] to_cnt_r;

    logic        in_edit_s;
    logic        any_btn_s;
    logic        adj_up_s;
    logic        adj_dn_s;
    logic        timeout_s;
    logic        capture_s;

    logic [3:0]  hr_l_s, hr_r_s, min_l_s, min_r_s;
    logic [3:0]  hr_l_nxt_s, hr_r_nxt_s, min_l_nxt_s, min_r_nxt_s;

    logic [3:0]  hr_left_r, hr_right_r, min_left_r, min_right_r;
    logic [3:0]  hr_left_nxt_s, hr_right_nxt_s, min_left_nxt_s, min_right_nxt_s;
    logic [3:0]  blank_r;
    logic [3:0]  blank_nxt_s;
    logic        load_r;
    logic        load_nxt_s;

    // Mode beats up/down; up and down together cancel each other.
    assign in_edit_s = (state_r == ST_SET_HR) || (state_r == ST_SET_MIN);
    assign any_btn_s = btn_mode_i | btn_up_i | btn_down_i;
    assign adj_up_s  = btn_up_i & ~btn_down_i & ~btn_mode_i;
    assign adj_dn_s  = btn_down_i & ~btn_up_i & ~btn_mode_i;
    assign timeout_s = in_edit_s && !any_btn_s && (to_cnt_r == (TIMEOUT - 32'd1));
    assign capture_s = (state_r == ST_RUN) && btn_mode_i;

    bcd_updown_pair #(.MAX(HR_MAX)) u_hours (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (capture_s),
        .load_left_i  (run_hr_left_i),
        .load_right_i (run_hr_right_i),
        .inc_i        ((state_r == ST_SET_HR) && adj_up_s),
        .dec_i        ((state_r == ST_SET_HR) && adj_dn_s),
        .left_o       (hr_l_s),
        .right_o      (hr_r_s),
        .nxt_left_o   (hr_l_nxt_s),
        .nxt_right_o  (hr_r_nxt_s)
    );

    bcd_updown_pair #(.MAX(MIN_MAX)) u_minutes (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (capture_s),
        .load_left_i  (run_min_left_i),
        .load_right_i (run_min_right_i),
        .inc_i        ((state_r == ST_SET_MIN) && adj_up_s),
        .dec_i        ((state_r == ST_SET_MIN) && adj_dn_s),
        .left_o       (min_l_s),
        .right_o      (min_r_s),
        .nxt_left_o   (min_l_nxt_s),
        .nxt_right_o  (min_r_nxt_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: mode advances, idle timeout abandons the edit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (btn_mode_i) state_nxt_s = ST_SET_HR;
                else            state_nxt_s = ST_RUN;
            end
            ST_SET_HR: begin
                if (btn_mode_i)     state_nxt_s = ST_SET_MIN;
                else if (timeout_s) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_SET_HR;
            end
            ST_SET_MIN: begin
                if (btn_mode_i)     state_nxt_s = ST_COMMIT;
                else if (timeout_s) state_nxt_s = ST_RUN;
                else                state_nxt_s = ST_SET_MIN;
            end
            ST_COMMIT: state_nxt_s = ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Blink phase: free-running, restarted in the visible phase by any edit button.
    always_comb begin
        blink_cnt_nxt_s = blink_cnt_r;
        phase_on_nxt_s  = phase_on_r;
        if (in_edit_s && any_btn_s) begin
            blink_cnt_nxt_s = 32'd0;
            phase_on_nxt_s  = 1'b1;
        end else if (blink_cnt_r == (BLINK_HALF - 32'd1)) begin
            blink_cnt_nxt_s = 32'd0;
            phase_on_nxt_s  = ~phase_on_r;
        end else begin
            blink_cnt_nxt_s = blink_cnt_r + 32'd1;
            phase_on_nxt_s  = phase_on_r;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            blink_cnt_r <= 32'd0;
            phase_on_r  <= 1'b1;
        end else begin
            blink_cnt_r <= blink_cnt_nxt_s;
            phase_on_r  <= phase_on_nxt_s;
        end
    end

    // Idle timeout counter: counts only while editing with no button activity.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_r <= 32'd0;
        end else if (!in_edit_s || any_btn_s || timeout_s) begin
            to_cnt_r <= 32'd0;
        end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end
    end

    // Output decode: choose display source, blank mask and load strobe for next cycle.
    always_comb begin
        hr_left_nxt_s   = run_hr_left_i;
        hr_right_nxt_s  = run_hr_right_i;
        min_left_nxt_s  = run_min_left_i;
        min_right_nxt_s = run_min_right_i;
        case (state_r)
            ST_RUN: begin
                if (btn_mode_i) begin
                    hr_left_nxt_s   = hr_l_nxt_s;
                    hr_right_nxt_s  = hr_r_nxt_s;
                    min_left_nxt_s  = min_l_nxt_s;
                    min_right_nxt_s = min_r_nxt_s;
                end else begin
                    hr_left_nxt_s   = run_hr_left_i;
                    hr_right_nxt_s  = run_hr_right_i;
                    min_left_nxt_s  = run_min_left_i;
                    min_right_nxt_s = run_min_right_i;
                end
            end
            ST_SET_HR, ST_SET_MIN: begin
                hr_left_nxt_s   = hr_l_nxt_s;
                hr_right_nxt_s  = hr_r_nxt_s;
                min_left_nxt_s  = min_l_nxt_s;
                min_right_nxt_s = min_r_nxt_s;
            end
            ST_COMMIT: begin
                hr_left_nxt_s   = hr_l_s;
                hr_right_nxt_s  = hr_r_s;
                min_left_nxt_s  = min_l_s;
                min_right_nxt_s = min_r_s;
            end
            default: begin
                hr_left_nxt_s   = run_hr_left_i;
                hr_right_nxt_s  = run_hr_right_i;
                min_left_nxt_s  = run_min_left_i;
                min_right_nxt_s = run_min_right_i;
            end
        endcase

        blank_nxt_s = 4'b0000;
        if (!phase_on_nxt_s) begin
            case (state_nxt_s)
                ST_SET_HR:  blank_nxt_s = BLANK_HR;
                ST_SET_MIN: blank_nxt_s = BLANK_MIN;
                default:    blank_nxt_s = 4'b0000;
            endcase
        end else begin
            blank_nxt_s = 4'b0000;
        end

        load_nxt_s = (state_nxt_s == ST_COMMIT);
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hr_left_r   <= 4'd0;
            hr_right_r  <= 4'd0;
            min_left_r  <= 4'd0;
            min_right_r <= 4'd0;
            blank_r     <= 4'b0000;
            load_r      <= 1'b0;
        end else begin
            hr_left_r   <= hr_left_nxt_s;
            hr_right_r  <= hr_right_nxt_s;
            min_left_r  <= min_left_nxt_s;
            min_right_r <= min_right_nxt_s;
            blank_r     <= blank_nxt_s;
            load_r      <= load_nxt_s;
        end
    end

    assign hr_left_o   = hr_left_r;
    assign hr_right_o  = hr_right_r;
    assign min_left_o  = min_left_r;
    assign min_right_o = min_right_r;
    assign blank_o     = blank_r;
    assign load_o      = load_r;
    assign mode_o      = state_r;

endmodule
